fir_band_scheduler: RTL and testbench

//  Sequences the banked FIR filters (LP/BP/HP, ROM-coefficient MAC type) one band at a time:

---
 rtl/fir_band_scheduler.sv | 161 ++++++++++++++++
 tb/tb_fir_band_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_band_scheduler.sv
// fir_band_scheduler
// Steps the banked ROM-coefficient FIR filters one band at a time. For each band it
// raises that band's 'sequencing' line for one full coefficient pass, then latches the
// band's L/R result. One sample request can wait while a pass is running. A request
// that arrives while another is already waiting is dropped, and the sticky overrun
// flag records the loss.
module fir_band_scheduler #(
    parameter int NUM_BANDS = 5,
    parameter int RUN_CYC   = 1023,
    parameter int GAP_CYC   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      smpl_vld,
    input  logic                      clr_ovr,
    input  logic [16*NUM_BANDS-1:0]   filt_L,
    input  logic [16*NUM_BANDS-1:0]   filt_R,
    output logic [NUM_BANDS-1:0]      seq,
    output logic [NUM_BANDS-1:0]      cap,
    output logic [16*NUM_BANDS-1:0]   res_L,
    output logic [16*NUM_BANDS-1:0]   res_R,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun
);

    localparam int BAND_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int CNT_MAX = (RUN_CYC > GAP_CYC) ? RUN_CYC : GAP_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(RUN_CYC - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(NUM_BANDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_CAPT,
        S_GAP,
        S_DONE
    } state_t;

    state_t                   r_state;
    logic [BAND_W-1:0]        r_band;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_pending;
    logic                     r_overrun;
    logic                     r_busy;
    logic                     r_done;
    logic [NUM_BANDS-1:0]     r_seq;
    logic [NUM_BANDS-1:0]     r_cap;
    logic [16*NUM_BANDS-1:0]  r_res_L;
    logic [16*NUM_BANDS-1:0]  r_res_R;

    logic [NUM_BANDS-1:0]     w_band_onehot;

    assign w_band_onehot = NUM_BANDS'(1) << r_band;

    // Band sequencer FSM. The request queue, the overrun flag and the result latches
    // are in the same block, so every output is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the result registers are plain flops rather than a memory, so they are
            // cleared here like all other state. A pass aborted by reset leaves them at zero.
            r_state   <= S_IDLE;
            r_band    <= '0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_seq     <= '0;
            r_cap     <= '0;
            r_res_L   <= '0;
            r_res_R   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout. A later assignment in this block
            // (for example the IDLE consume of r_pending) wins over an earlier default.
            r_cap  <= '0;
            r_done <= 1'b0;

            // A request that arrives while one is already waiting is lost. A new loss in
            // the same cycle as clr_ovr keeps the flag set.
            if (smpl_vld && r_pending) begin
                r_overrun <= 1'b1;
            end else if (clr_ovr) begin
                r_overrun <= 1'b0;
            end

            if (r_state != S_IDLE && smpl_vld) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (smpl_vld || r_pending) begin
                        r_state   <= S_RUN;
                        r_band    <= '0;
                        r_cnt     <= '0;
                        r_pending <= 1'b0;
                        r_seq     <= NUM_BANDS'(1);
                        r_busy    <= 1'b1;
                    end
                end

                S_RUN: begin
                    if (r_cnt == RUN_LAST) begin
                        r_state <= S_CAPT;
                        r_seq   <= '0;
                        r_cap   <= w_band_onehot;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_CAPT: begin
                    r_res_L[16*r_band +: 16] <= filt_L[16*r_band +: 16];
                    r_res_R[16*r_band +: 16] <= filt_R[16*r_band +: 16];
                    r_cnt                    <= '0;
                    if (r_band == BAND_LAST) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state <= S_RUN;
                        r_band  <= r_band + 1'b1;
                        r_cnt   <= '0;
                        r_seq   <= w_band_onehot << 1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_seq   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign seq     = r_seq;
    assign cap     = r_cap;
    assign res_L   = r_res_L;
    assign res_R   = r_res_R;
    assign busy    = r_busy;
    assign done    = r_done;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_fir_band_scheduler.sv
// tb_fir_band_scheduler
// Small configuration: 2 bands, 8 run cycles, 2 gap cycles. The bench uses directed
// timing tables, hand sequences for queue, overrun and reset corners, and a long
// random run. All of these are compared against a pass-schedule model of the scheduler.
module tb_fir_band_scheduler;

    localparam int NB   = 2;
    localparam int RUN  = 8;
    localparam int GAP  = 2;
    localparam int D    = NB*(RUN+1) + (NB-1)*GAP;   // pass start to done cycle
    localparam int MAXC = 3200;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 smpl_vld;
    logic                 clr_ovr;
    logic [16*NB-1:0]     filt_L;
    logic [16*NB-1:0]     filt_R;
    logic [NB-1:0]        seq;
    logic [NB-1:0]        cap;
    logic [16*NB-1:0]     res_L;
    logic [16*NB-1:0]     res_R;
    logic                 busy;
    logic                 done;
    logic                 overrun;

    fir_band_scheduler #(.NUM_BANDS(NB), .RUN_CYC(RUN), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .smpl_vld(smpl_vld), .clr_ovr(clr_ovr),
        .filt_L(filt_L), .filt_R(filt_R), .seq(seq), .cap(cap),
        .res_L(res_L), .res_R(res_R), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // stimulus and observation, indexed by cycle number within one trace
    logic            st_vld [MAXC];
    logic            st_clr [MAXC];
    logic [16*NB-1:0] st_L  [MAXC];
    logic [16*NB-1:0] st_R  [MAXC];
    logic [NB-1:0]   ob_seq [MAXC];
    logic [NB-1:0]   ob_cap [MAXC];
    logic            ob_busy[MAXC];
    logic            ob_done[MAXC];
    logic            ob_ovr [MAXC];
    logic [16*NB-1:0] ob_L  [MAXC];
    logic [16*NB-1:0] ob_R  [MAXC];
    // model expectations
    logic [NB-1:0]   ex_seq [MAXC];
    logic [NB-1:0]   ex_cap [MAXC];
    logic            ex_busy[MAXC];
    logic            ex_done[MAXC];
    logic            ex_ovr [MAXC];
    logic [16*NB-1:0] ex_L  [MAXC];
    logic [16*NB-1:0] ex_R  [MAXC];

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int           cyc;
        logic [NB-1:0] seq;
        logic [NB-1:0] cap;
        logic         busy;
        logic         done;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input int cyc, input logic [127:0] act,
                         input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        smpl_vld = 1'b0;
        clr_ovr  = 1'b0;
        filt_L   = '0;
        filt_R   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stim(input int n);
        for (int c = 0; c < n; c++) begin
            st_vld[c] = 1'b0;
            st_clr[c] = 1'b0;
            st_L[c]   = {$urandom, $urandom} & {(16*NB){1'b1}};
            st_R[c]   = {$urandom, $urandom} & {(16*NB){1'b1}};
        end
    endtask

    // Applies cycles 0..n-1. Inputs are driven just after the rising edge and outputs
    // are sampled on the falling edge.
    task automatic run_trace(input int n);
        for (int c = 0; c < n; c++) begin
            smpl_vld = st_vld[c];
            clr_ovr  = st_clr[c];
            filt_L   = st_L[c];
            filt_R   = st_R[c];
            @(negedge clk);
            ob_seq[c]  = seq;
            ob_cap[c]  = cap;
            ob_busy[c] = busy;
            ob_done[c] = done;
            ob_ovr[c]  = overrun;
            ob_L[c]    = res_L;
            ob_R[c]    = res_R;
            @(posedge clk);
            #1;
        end
        smpl_vld = 1'b0;
        clr_ovr  = 1'b0;
    endtask

    // Pass-level model. A pass accepted in idle cycle c starts at s=c+1. Band b runs for
    // RUN cycles from s+b*(RUN+1+GAP), its capture comes right after, done is at s+D, and
    // the block is busy over [s, s+D].
    task automatic build_model(input int n);
        int               last_done;
        bit               pend;
        bit               ovr;
        logic [16*NB-1:0] rl;
        logic [16*NB-1:0] rr;
        last_done = -1;
        pend      = 1'b0;
        ovr       = 1'b0;
        rl        = '0;
        rr        = '0;
        for (int c = 0; c < n; c++) begin
            ex_seq[c] = '0; ex_cap[c] = '0; ex_busy[c] = 1'b0; ex_done[c] = 1'b0;
        end
        for (int c = 0; c < n; c++) begin
            bit lost;
            ex_ovr[c] = ovr;
            ex_L[c]   = rl;
            ex_R[c]   = rr;
            for (int b = 0; b < NB; b++) begin
                if (ex_cap[c][b]) begin
                    rl[16*b +: 16] = st_L[c][16*b +: 16];
                    rr[16*b +: 16] = st_R[c][16*b +: 16];
                end
            end
            lost = st_vld[c] && pend;
            if (c > last_done) begin
                if (st_vld[c] || pend) begin
                    int s;
                    s = c + 1;
                    last_done = s + D;
                    pend = 1'b0;
                    for (int b = 0; b < NB; b++) begin
                        int base;
                        base = s + b*(RUN+1+GAP);
                        for (int t = base; t < base + RUN; t++)
                            if (t < n) ex_seq[t][b] = 1'b1;
                        if (base + RUN < n) ex_cap[base+RUN][b] = 1'b1;
                    end
                    for (int t = s; t <= s + D; t++)
                        if (t < n) ex_busy[t] = 1'b1;
                    if (s + D < n) ex_done[s+D] = 1'b1;
                end
            end else if (st_vld[c]) begin
                pend = 1'b1;
            end
            if (lost) ovr = 1'b1;
            else if (st_clr[c]) ovr = 1'b0;
        end
    endtask

    task automatic model_check(input string name, input int n);
        build_model(n);
        for (int c = 0; c < n; c++) begin
            check(name, c,
                  128'({ob_seq[c], ob_cap[c], ob_busy[c], ob_done[c], ob_ovr[c], ob_L[c], ob_R[c]}),
                  128'({ex_seq[c], ex_cap[c], ex_busy[c], ex_done[c], ex_ovr[c], ex_L[c], ex_R[c]}));
        end
    endtask

    initial begin
        tbl[0]  = '{0,  2'b00, 2'b00, 1'b0, 1'b0};
        tbl[1]  = '{1,  2'b01, 2'b00, 1'b1, 1'b0};
        tbl[2]  = '{2,  2'b01, 2'b00, 1'b1, 1'b0};
        tbl[3]  = '{8,  2'b01, 2'b00, 1'b1, 1'b0};
        tbl[4]  = '{9,  2'b00, 2'b01, 1'b1, 1'b0};
        tbl[5]  = '{10, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[6]  = '{11, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[7]  = '{12, 2'b10, 2'b00, 1'b1, 1'b0};
        tbl[8]  = '{19, 2'b10, 2'b00, 1'b1, 1'b0};
        tbl[9]  = '{20, 2'b00, 2'b10, 1'b1, 1'b0};
        tbl[10] = '{21, 2'b00, 2'b00, 1'b1, 1'b1};
        tbl[11] = '{22, 2'b00, 2'b00, 1'b0, 1'b0};

        // reset, then idle
        do_reset();
        clear_stim(20);
        run_trace(20);
        for (int c = 0; c < 20; c += 19)
            check("idle", c, 128'({ob_seq[c], ob_cap[c], ob_busy[c], ob_done[c], ob_ovr[c], ob_L[c], ob_R[c]}), 128'(0));

        // single pass timing table
        do_reset();
        clear_stim(30);
        st_vld[0] = 1'b1;
        run_trace(30);
        for (int i = 0; i < 12; i++)
            check("pass_tbl", tbl[i].cyc,
                  128'({ob_seq[tbl[i].cyc], ob_cap[tbl[i].cyc], ob_busy[tbl[i].cyc], ob_done[tbl[i].cyc]}),
                  128'({tbl[i].seq, tbl[i].cap, tbl[i].busy, tbl[i].done}));
        check("res_L", 22, 128'(ob_L[22]), 128'({st_L[20][31:16], st_L[9][15:0]}));
        check("res_R", 22, 128'(ob_R[22]), 128'({st_R[20][31:16], st_R[9][15:0]}));
        model_check("pass_model", 30);

        // reset in the middle of band 1 of a second pass
        clear_stim(14);
        st_vld[0] = 1'b1;
        run_trace(14);
        rst_n = 1'b0;
        #1;
        check("rst_mid", 14, 128'({seq, cap, busy, done, overrun, res_L, res_R}), 128'(0));
        do_reset();

        // second request queued while busy
        clear_stim(50);
        st_vld[0] = 1'b1;
        st_vld[5] = 1'b1;
        run_trace(50);
        check("pend_seq22", 22, 128'(ob_seq[22]), 128'(2'b00));
        check("pend_seq23", 23, 128'(ob_seq[23]), 128'(2'b01));
        check("pend_ovr", 49, 128'(ob_ovr[49]), 128'(0));
        model_check("pend_model", 50);

        // overrun set, then cleared
        do_reset();
        clear_stim(14);
        st_vld[0] = 1'b1; st_vld[5] = 1'b1; st_vld[6] = 1'b1;
        st_clr[10] = 1'b1;
        run_trace(14);
        check("ovr6", 6, 128'(ob_ovr[6]), 128'(0));
        check("ovr7", 7, 128'(ob_ovr[7]), 128'(1));
        check("ovr10", 10, 128'(ob_ovr[10]), 128'(1));
        check("ovr11", 11, 128'(ob_ovr[11]), 128'(0));

        // clear in the same cycle as a new overrun
        do_reset();
        clear_stim(10);
        st_vld[0] = 1'b1; st_vld[5] = 1'b1; st_vld[6] = 1'b1;
        st_clr[6] = 1'b1;
        run_trace(10);
        check("ovr_clr_same", 7, 128'(ob_ovr[7]), 128'(1));

        // request in the DONE cycle
        do_reset();
        clear_stim(50);
        st_vld[0]  = 1'b1;
        st_vld[21] = 1'b1;
        run_trace(50);
        check("done21", 21, 128'(ob_done[21]), 128'(1));
        check("dn_seq22", 22, 128'(ob_seq[22]), 128'(2'b00));
        check("dn_seq23", 23, 128'(ob_seq[23]), 128'(2'b01));
        check("dn_ovr", 49, 128'(ob_ovr[49]), 128'(0));
        model_check("done_model", 50);

        // random traffic
        do_reset();
        clear_stim(3000);
        for (int c = 0; c < 3000; c++) begin
            st_vld[c] = ($urandom_range(0, 14) == 0);
            st_clr[c] = ($urandom_range(0, 39) == 0);
        end
        run_trace(3000);
        model_check("rand", 3000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
